// File: rtl/piano_pkg.sv
// Shared constants and helpers for the piano tone generator / note detector pair:
// note half-periods, classification boundaries and the detector state encoding.
package piano_pkg;

  localparam int NOTE_W = 4;
  localparam int HP_W   = 17;

  typedef logic [HP_W-1:0] hp_t;

  // Half-period in 50 MHz clk cycles for each note code, lowest note first
  localparam hp_t HALF_PERIOD [16] = '{
    17'd113635, 17'd107258, 17'd101238, 17'd95556,
    17'd90194,  17'd85131,  17'd80353,  17'd75843,
    17'd71586,  17'd67568,  17'd63776,  17'd60197,
    17'd56818,  17'd53629,  17'd50619,  17'd47778
  };

  // Descending class boundaries: class k covers BOUND[k+1] <= m < BOUND[k]
  localparam hp_t BOUND [17] = '{
    17'd116825, 17'd110446, 17'd104247, 17'd98396,
    17'd92873,  17'd87661,  17'd82741,  17'd78097,
    17'd73713,  17'd69576,  17'd65671,  17'd61985,
    17'd58506,  17'd55222,  17'd52123,  17'd49197,
    17'd46357
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic              in_range;
    logic [NOTE_W-1:0] code;
  } class_t;

  function automatic class_t classify(input hp_t m);
    class_t c;
    c.in_range = 1'b0;
    c.code     = {NOTE_W{1'b0}};
    for (int k = 0; k < 16; k++) begin
      if ((m < BOUND[k]) && (m >= BOUND[k+1])) begin
        c.in_range = 1'b1;
        c.code     = NOTE_W'(k);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/piano_note_detector_if.sv
// Tone input and decoded-note outputs of the piano note detector.
interface piano_note_detector_if;
  import piano_pkg::*;

  logic              tone_in;
  logic [NOTE_W-1:0] note;
  logic              note_valid;
  logic              note_strobe;
  logic              silent;

  modport master (output tone_in, input note, note_valid, note_strobe, silent);
  modport slave  (input tone_in, output note, note_valid, note_strobe, silent);
endinterface

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer for the asynchronous tone input followed by a
// registered any-edge pulse (visible 3 clk after the input toggles).
module tone_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic edge_r;

  // Synchronize the input and flag any change of the synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      edge_r  <= sync2_r ^ prev_r;
    end
  end

  assign edge_pulse = edge_r;

endmodule

// File: rtl/piano_note_detector.sv
// Decodes a square-wave tone back to its 4-bit note code by timing each
// half-period and locking once STABLE consecutive half-periods agree.
module piano_note_detector
  import piano_pkg::*;
#(
  parameter int unsigned     STABLE  = 4,
  parameter logic [HP_W-1:0] TIMEOUT = 17'd120000
) (
  input logic                  clk,
  input logic                  rst_n,
  piano_note_detector_if.slave bus
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);
  localparam hp_t        CNT_MAX  = 17'h1FFFF;

  logic              edge_s;
  hp_t               counter_r;
  state_t            state_r;
  state_t            state_s;
  class_t            cls_s;
  logic              same_s;
  logic              timeout_s;
  logic [3:0]        run_r;
  logic [3:0]        run_s;
  logic [3:0]        run_inc_s;
  logic [NOTE_W-1:0] cand_r;
  logic [NOTE_W-1:0] cand_s;
  logic [NOTE_W-1:0] note_r;
  logic [NOTE_W-1:0] note_s;
  logic              valid_r;
  logic              valid_s;
  logic              strobe_r;
  logic              strobe_s;
  logic              silent_r;
  logic              silent_s;

  tone_edge_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (bus.tone_in),
    .edge_pulse (edge_s)
  );

  // Half-period counter: restarts at 1 on every edge, saturates instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_r <= {HP_W{1'b0}};
    end else if (edge_s) begin
      counter_r <= 17'd1;
    end else if (counter_r != CNT_MAX) begin
      counter_r <= counter_r + 17'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus candidate/run tracking; an edge takes priority over timeout
  always_comb begin
    cls_s     = classify(counter_r);
    same_s    = cls_s.in_range && (cls_s.code == cand_r);
    timeout_s = (counter_r == TIMEOUT);
    run_inc_s = (run_r < STABLE_C) ? (run_r + 4'd1) : run_r;
    state_s   = state_r;
    run_s     = run_r;
    cand_s    = cand_r;
    case (state_r)
      IDLE: begin
        // The first edge only starts timing; the counter was not measuring a full half-period
        if (edge_s) begin
          state_s = MEASURE;
        end else begin
          state_s = IDLE;
        end
      end
      MEASURE, LOCKED: begin
        if (edge_s) begin
          if (!cls_s.in_range) begin
            run_s   = 4'd0;
            state_s = MEASURE;
          end else if (same_s) begin
            run_s   = run_inc_s;
            state_s = (run_inc_s == STABLE_C) ? LOCKED : MEASURE;
          end else begin
            run_s   = 4'd1;
            cand_s  = cls_s.code;
            state_s = (STABLE_C == 4'd1) ? LOCKED : MEASURE;
          end
        end else if (timeout_s) begin
          run_s   = 4'd0;
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        run_s   = 4'd0;
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle; note holds its last value outside LOCKED
  always_comb begin
    valid_s = (state_s == LOCKED);
    if (valid_s) begin
      note_s = cand_s;
    end else begin
      note_s = note_r;
    end
    strobe_s = valid_s && (!valid_r || (note_s != note_r));
    silent_s = (state_s == IDLE);
  end

  // Registered tracking state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r    <= 4'd0;
      cand_r   <= {NOTE_W{1'b0}};
      note_r   <= {NOTE_W{1'b0}};
      valid_r  <= 1'b0;
      strobe_r <= 1'b0;
      silent_r <= 1'b1;
    end else begin
      run_r    <= run_s;
      cand_r   <= cand_s;
      note_r   <= note_s;
      valid_r  <= valid_s;
      strobe_r <= strobe_s;
      silent_r <= silent_s;
    end
  end

  assign bus.note        = note_r;
  assign bus.note_valid  = valid_r;
  assign bus.note_strobe = strobe_r;
  assign bus.silent      = silent_r;

endmodule

// File: tb/tb_piano_note_detector.sv
// Table-driven bench for piano_note_detector: each vector is one half-period
// followed by the outputs expected 4 clk after the edge that ends it.
module tb_piano_note_detector;
  import piano_pkg::*;

  typedef struct {
    int         hp;
    logic [3:0] note;
    logic       valid;
    logic       strobe;
    logic       silent;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q [$];
  vec_t       tbl [37];

  piano_note_detector_if bus ();

  piano_note_detector #(.STABLE(4), .TIMEOUT(17'd120000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int hp, input logic [3:0] n, input logic v,
                              input logic s, input logic si);
    vec_t r;
    r.hp = hp; r.note = n; r.valid = v; r.strobe = s; r.silent = si;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] n, input logic v,
                         input logic s, input logic si);
    chk({tag, "_note"},   int'(bus.note),        int'(n));
    chk({tag, "_valid"},  int'(bus.note_valid),  int'(v));
    chk({tag, "_strobe"}, int'(bus.note_strobe), int'(s));
    chk({tag, "_silent"}, int'(bus.silent),      int'(si));
  endtask

  // Wait out the half-period, toggle, then check the classified result 4 clk later
  task automatic apply(input int idx, input vec_t v);
    repeat (v.hp - 4) @(posedge clk);
    #1;
    if (v.strobe) exp_q.push_back(v.note);
    bus.tone_in = ~bus.tone_in;
    repeat (4) @(posedge clk);
    #1;
    chk_out($sformatf("vec%0d", idx), v.note, v.valid, v.strobe, v.silent);
  endtask

  // Strobe scoreboard: every strobe must match a queued expectation and carry note_valid
  always @(negedge clk) begin : sb_mon
    logic [3:0] e;
    if (rst_n === 1'b1 && bus.note_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_strobe: got note %0d expected no strobe", bus.note);
      end else begin
        e = exp_q.pop_front();
        chk("sb_note", int'(bus.note), int'(e));
      end
      chk("sb_strobe_valid", int'(bus.note_valid), 1);
    end
  end

  initial begin
    int h0, h1, h3, h8, h15;
    h0  = int'(HALF_PERIOD[0]);
    h1  = int'(HALF_PERIOD[1]);
    h3  = int'(HALF_PERIOD[3]);
    h8  = int'(HALF_PERIOD[8]);
    h15 = int'(HALF_PERIOD[15]);

    tbl[0] = mk(10, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) tbl[i] = mk(h3, 4'd0, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk(h3, 4'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 5; i <= 7; i++) tbl[i] = mk(h15, 4'd3, 1'b0, 1'b0, 1'b0);
    tbl[8] = mk(h15, 4'd15, 1'b1, 1'b1, 1'b0);
    for (int i = 9; i <= 11; i++) tbl[i] = mk(h0, 4'd15, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(h0, 4'd0, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk(40000, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 14; i <= 16; i++) tbl[i] = mk(h0, 4'd0, 1'b0, 1'b0, 1'b0);
    tbl[17] = mk(110446, 4'd0, 1'b1, 1'b1, 1'b0);
    tbl[18] = mk(116825, 4'd0, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(110445, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 20; i <= 21; i++) tbl[i] = mk(h1, 4'd0, 1'b0, 1'b0, 1'b0);
    tbl[22] = mk(h1, 4'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 23; i <= 25; i++) tbl[i] = mk(h15, 4'd1, 1'b0, 1'b0, 1'b0);
    tbl[26] = mk(46357, 4'd15, 1'b1, 1'b1, 1'b0);
    tbl[27] = mk(46356, 4'd15, 1'b0, 1'b0, 1'b0);
    for (int i = 28; i <= 30; i++) tbl[i] = mk(h8, 4'd15, 1'b0, 1'b0, 1'b0);
    tbl[31] = mk(h8, 4'd8, 1'b1, 1'b1, 1'b0);
    tbl[32] = mk(10, 4'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 33; i <= 35; i++) tbl[i] = mk(h15, 4'd8, 1'b0, 1'b0, 1'b0);
    tbl[36] = mk(h15, 4'd15, 1'b1, 1'b1, 1'b0);

    bus.tone_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    repeat (200000) @(posedge clk);
    #1;
    chk_out("idle", 4'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i <= 31; i++) apply(i, tbl[i]);

    // Locked on note 8, tone stops: counter hits TIMEOUT 119999 clk after this point
    repeat (119999) @(posedge clk);
    #1;
    chk_out("pre_timeout", 4'd8, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("timeout", 4'd8, 1'b0, 1'b0, 1'b1);

    for (int i = 32; i <= 36; i++) apply(i, tbl[i]);

    // Asynchronous reset while locked on note 15
    repeat (50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 4'd0, 1'b0, 1'b0, 1'b1);
    bus.tone_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_out("post_reset", 4'd0, 1'b0, 1'b0, 1'b1);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
